acia_uart_rx: RTL and testbench
===============================

Name: acia_uart_rx

Overview:
- Serial receiver half of the SuperSerial card: the receive counterpart of the card's uart_tx_o path. It consumes the uart_rx pin.
- Recovers asynchronous frames using 16x oversampling and a programmable divisor.
- Queues characters with per-character error flags in a small FIFO, which the SuperSerial 6551 register logic reads.
- Runs entirely in the clk_logic domain.

Parameters:
- FIFO_DEPTH, 4, receive FIFO entries; must be a power of 2, 2..16.
- OVERSAMPLE, 16, oversample ticks per bit; fixed at 16, mid-bit sample is tick 7.

Ports:
- clk  in  1  logic clock (54 MHz).
- reset  in  1  asynchronous, active-high reset.
- baud_div_i  in  16  clocks per oversample tick minus 1.
- word_len_i  in  2  6551 encoding: 00=8, 01=7, 10=6, 11=5 data bits.
- parity_en_i  in  1  parity bit present.
- parity_mode_i  in  2  00=odd, 01=even, 10=mark, 11=space.
- rx_i  in  1  raw serial input, asynchronous, idle high.
- rd_i  in  1  pop head entry (one-cycle strobe).
- clr_err_i  in  1  clear sticky overrun_o.
- data_o  out  8  head character; unused upper bits are 0.
- valid_o  out  1  FIFO non-empty.
- parity_err_o  out  1  parity error flag of the head entry.
- framing_err_o  out  1  framing error flag of the head entry.
- break_o  out  1  head entry is a break.
- overrun_o  out  1  sticky: a character was dropped because the FIFO was full.
- count_o  out  5  FIFO occupancy.

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- Reset values: data_o=0, valid_o=0, all error outputs 0, count_o=0, FSM in IDLE, synchroniser outputs 1.
- Input path: rx_i passes through a 2-FF synchroniser. All FSM decisions use the synchronised signal.
- Tick generator: down-counter reloaded from baud_div_i, one-cycle tick when the count reaches 0.
  - baud_div_i=0 gives a tick every clock.
  - A change to baud_div_i takes effect at the next reload.
  - The counter free-runs; it is not phase-aligned to the start edge.
- Sample counter: 4 bits, increments on each tick. It is cleared on entry to START, DATA, PARITY and STOP.
- Bit value: majority vote of the samples taken at ticks 7, 8 and 9. The bit is resolved at tick 9.
- FSM states: IDLE, START, DATA, PARITY, STOP, WAIT_IDLE.
  - IDLE: synchronised rx low -> START.
  - START: resolved bit 0 -> DATA with bit index 0. Resolved bit 1 (false start) -> IDLE.
  - DATA: each bit is shifted in LSB-first at tick 15 boundaries. After word_len bits -> PARITY if parity_en_i, else STOP.
  - PARITY: compare the resolved bit to the expected value.
    - odd/even: computed over the received data bits only.
    - mark: expected 1. space: expected 0.
  - STOP: resolve the first stop bit; extra stop bits are ignored.
    - Push the entry {data, perr, ferr = (stop==0), brk} on the resolve tick.
    - brk = ferr AND all data bits 0 AND parity bit 0.
    - Stop 1 -> IDLE. Stop 0 -> WAIT_IDLE.
  - WAIT_IDLE: stay until synchronised rx is 1, then -> IDLE. This prevents a held break from producing repeated frames.
- FIFO behaviour:
  - Head is visible combinationally; valid_o and count_o update the cycle after a push or pop.
  - rd_i while empty: ignored.
  - Push while full without a pop in the same cycle: new character dropped, overrun_o set to 1. The FIFO is unchanged.
  - Simultaneous push and pop while full: both succeed, count unchanged, no overrun.
  - Simultaneous push and pop while empty: the push lands, count becomes 1.
- overrun_o: cleared by clr_err_i. If a set and a clear occur in the same cycle, set wins.
- Config inputs (word_len_i, parity_en_i, parity_mode_i) are sampled on entry to DATA and held for the frame.
- Reset mid-frame: the frame is discarded and the FIFO is emptied. Reception restarts in IDLE.
- Latency: valid_o rises 1 clk after the stop-bit resolve tick. That is 2 sync clocks + 9.5 bit times + 2 ticks after the start edge (8N1).

Decomposition:
- uart_pkg:
  - rx_state_t enum (the six states).
  - parity_mode_t enum.
  - word_len encoding constants.
  - MID_SAMPLE=7 and LAST_VOTE=9 constants.
  - rx_entry_t packed struct {data[7:0], perr, ferr, brk}.
- Sub-module uart_rx_fifo: synchronous FIFO of rx_entry_t, parameterised by FIFO_DEPTH.
  - Push, pop, full, empty, count.
  - Implements the simultaneous push/pop rules above.

Test Plan:
- 8N1 at baud_div_i=28 (≈116 kbaud), send 0xA5 -> valid_o=1, data_o=0xA5, all error outputs 0; rd_i pulse -> valid_o=0, count_o=0.
- 7-bit, even parity, send 0x41 with parity bit 1 (wrong) -> data_o=0x41, parity_err_o=1, framing_err_o=0. Repeat with parity bit 0 -> parity_err_o=0.
- Send 0x3C with stop bit 0, then rx high -> data_o=0x3C, framing_err_o=1, break_o=0.
  - Hold rx low for 3 frame times -> exactly one entry, data_o=0x00, break_o=1.
  - No further entries until rx returns high.
- Send 5 frames 0x01..0x05 without reads (FIFO_DEPTH=4) -> count_o=4, overrun_o=1; reads return 0x01..0x04.
  - clr_err_i -> overrun_o=0.
- Drive rx low for 4 oversample ticks only (glitch) -> no entry; FSM returns to IDLE; the next valid frame 0x7E is received correctly.
- Assert reset during DATA bit 3 of a frame, with 2 entries queued -> valid_o=0, count_o=0 during reset; the next frame 0x55 is received cleanly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the SuperSerial receive path.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_WAIT_IDLE
    } rx_state_t;

    typedef enum logic [1:0] {
        PAR_ODD   = 2'b00,
        PAR_EVEN  = 2'b01,
        PAR_MARK  = 2'b10,
        PAR_SPACE = 2'b11
    } parity_mode_t;

    localparam logic [1:0] WL_8 = 2'b00;
    localparam logic [1:0] WL_7 = 2'b01;
    localparam logic [1:0] WL_6 = 2'b10;
    localparam logic [1:0] WL_5 = 2'b11;

    localparam logic [3:0] MID_SAMPLE = 4'd7;
    localparam logic [3:0] LAST_VOTE  = 4'd9;

    typedef struct packed {
        logic [7:0] data;
        logic       perr;
        logic       ferr;
        logic       brk;
    } rx_entry_t;

    // Index of the final data bit for a 6551 word-length code.
    function automatic logic [2:0] last_bit_idx(input logic [1:0] wl);
        logic [2:0] idx;
        case (wl)
            WL_8:    idx = 3'd7;
            WL_7:    idx = 3'd6;
            WL_6:    idx = 3'd5;
            WL_5:    idx = 3'd4;
            default: idx = 3'd7;
        endcase
        return idx;
    endfunction

    function automatic logic parity_expect(input parity_mode_t mode, input logic [7:0] d);
        logic p;
        case (mode)
            PAR_ODD:   p = ~(^d);
            PAR_EVEN:  p = ^d;
            PAR_MARK:  p = 1'b1;
            PAR_SPACE: p = 1'b0;
            default:   p = 1'b0;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Small synchronous FIFO of received characters; a pop frees room for a same-cycle push.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       push_i,
    input  rx_entry_t  wdata_i,
    input  logic       pop_i,
    output rx_entry_t  head_o,
    output logic       full_o,
    output logic       empty_o,
    output logic       drop_o,
    output logic [4:0] count_o
);

    localparam int unsigned PW = $clog2(FIFO_DEPTH);

    rx_entry_t     mem_q [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [4:0]    count_q, count_d;
    logic          do_push, do_pop;

    assign empty_o = (count_q == 5'd0);
    assign full_o  = (count_q == 5'(FIFO_DEPTH));
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);
    assign drop_o  = push_i & ~do_push;
    assign head_o  = empty_o ? '0 : mem_q[rd_ptr_q];
    assign count_o = count_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = PW'(wr_ptr_q + 1'b1);
        if (do_pop)  rd_ptr_d = PW'(rd_ptr_q + 1'b1);
        case ({do_push, do_pop})
            2'b10:   count_d = 5'(count_q + 5'd1);
            2'b01:   count_d = 5'(count_q - 5'd1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/acia_uart_rx.sv
// 6551-style UART receiver: 16x oversampled frame recovery with 3-sample majority vote,
// feeding a character FIFO with per-entry parity/framing/break flags.
module acia_uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] baud_div_i,
    input  logic [1:0]  word_len_i,
    input  logic        parity_en_i,
    input  logic [1:0]  parity_mode_i,
    input  logic        rx_i,
    input  logic        rd_i,
    input  logic        clr_err_i,
    output logic [7:0]  data_o,
    output logic        valid_o,
    output logic        parity_err_o,
    output logic        framing_err_o,
    output logic        break_o,
    output logic        overrun_o,
    output logic [4:0]  count_o
);

    localparam logic [3:0] LAST_TICK = 4'(OVERSAMPLE - 1);

    rx_state_t    state_q, state_d;
    logic [1:0]   sync_q;
    logic [15:0]  tick_cnt_q;
    logic [3:0]   smp_q, smp_d;
    logic         s0_q, s0_d, s1_q, s1_d;
    logic [2:0]   bit_idx_q, bit_idx_d;
    logic [7:0]   data_q, data_d;
    logic [1:0]   wl_q, wl_d;
    logic         pen_q, pen_d;
    parity_mode_t pmode_q, pmode_d;
    logic         pbit_q, pbit_d;
    logic         perr_q, perr_d;
    logic         overrun_q;
    logic         rx_s, tick_c, resolve_c, bound_c, vote_c, push_c, drop_c, empty_c;
    rx_entry_t    entry_c, head_c;

    assign rx_s      = sync_q[1];
    assign tick_c    = (tick_cnt_q == 16'd0);
    assign resolve_c = tick_c && (smp_q == LAST_VOTE);
    assign bound_c   = tick_c && (smp_q == LAST_TICK);
    assign vote_c    = (s0_q & s1_q) | (s0_q & rx_s) | (s1_q & rx_s);

    // Synchroniser and free-running oversample tick divider.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q     <= 2'b11;
            tick_cnt_q <= '0;
        end else begin
            sync_q     <= {sync_q[0], rx_i};
            tick_cnt_q <= tick_c ? baud_div_i : 16'(tick_cnt_q - 16'd1);
        end
    end

    always_comb begin
        state_d   = state_q;
        smp_d     = smp_q;
        s0_d      = s0_q;
        s1_d      = s1_q;
        bit_idx_d = bit_idx_q;
        data_d    = data_q;
        wl_d      = wl_q;
        pen_d     = pen_q;
        pmode_d   = pmode_q;
        pbit_d    = pbit_q;
        perr_d    = perr_q;
        push_c    = 1'b0;
        entry_c   = '0;

        if (tick_c) begin
            smp_d = 4'(smp_q + 4'd1);
            if (smp_q == MID_SAMPLE)         s0_d = rx_s;
            if (smp_q == 4'(MID_SAMPLE + 1)) s1_d = rx_s;
        end

        case (state_q)
            ST_IDLE: begin
                if (!rx_s) state_d = ST_START;
            end
            ST_START: begin
                if (resolve_c && vote_c) begin
                    state_d = ST_IDLE;
                end else if (bound_c) begin
                    state_d   = ST_DATA;
                    bit_idx_d = '0;
                    data_d    = '0;
                    wl_d      = word_len_i;
                    pen_d     = parity_en_i;
                    pmode_d   = parity_mode_t'(parity_mode_i);
                    pbit_d    = 1'b0;
                    perr_d    = 1'b0;
                end
            end
            ST_DATA: begin
                if (resolve_c) data_d[bit_idx_q] = vote_c;
                if (bound_c) begin
                    if (bit_idx_q == last_bit_idx(wl_q)) state_d = pen_q ? ST_PARITY : ST_STOP;
                    else                                 bit_idx_d = 3'(bit_idx_q + 3'd1);
                end
            end
            ST_PARITY: begin
                if (resolve_c) begin
                    pbit_d = vote_c;
                    perr_d = (vote_c != parity_expect(pmode_q, data_q));
                end
                if (bound_c) state_d = ST_STOP;
            end
            ST_STOP: begin
                // Push on the stop-bit vote; a low stop bit parks in WAIT_IDLE so a held break yields one entry.
                if (resolve_c) begin
                    push_c       = 1'b1;
                    entry_c.data = data_q;
                    entry_c.perr = perr_q;
                    entry_c.ferr = ~vote_c;
                    entry_c.brk  = ~vote_c & (data_q == 8'd0) & ~pbit_q;
                    state_d      = vote_c ? ST_IDLE : ST_WAIT_IDLE;
                end
            end
            ST_WAIT_IDLE: begin
                if (rx_s) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if ((state_d != state_q) && (state_d inside {ST_START, ST_DATA, ST_PARITY, ST_STOP}))
            smp_d = '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            smp_q     <= '0;
            s0_q      <= 1'b1;
            s1_q      <= 1'b1;
            bit_idx_q <= '0;
            data_q    <= '0;
            wl_q      <= WL_8;
            pen_q     <= 1'b0;
            pmode_q   <= PAR_ODD;
            pbit_q    <= 1'b0;
            perr_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            smp_q     <= smp_d;
            s0_q      <= s0_d;
            s1_q      <= s1_d;
            bit_idx_q <= bit_idx_d;
            data_q    <= data_d;
            wl_q      <= wl_d;
            pen_q     <= pen_d;
            pmode_q   <= pmode_d;
            pbit_q    <= pbit_d;
            perr_q    <= perr_d;
            overrun_q <= drop_c ? 1'b1 : (clr_err_i ? 1'b0 : overrun_q);
        end
    end

    uart_rx_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (push_c),
        .wdata_i (entry_c),
        .pop_i   (rd_i),
        .head_o  (head_c),
        .full_o  (),
        .empty_o (empty_c),
        .drop_o  (drop_c),
        .count_o (count_o)
    );

    assign data_o        = head_c.data;
    assign parity_err_o  = head_c.perr;
    assign framing_err_o = head_c.ferr;
    assign break_o       = head_c.brk;
    assign valid_o       = ~empty_c;
    assign overrun_o     = overrun_q;

endmodule

// File: tb/tb_acia_uart_rx.sv
// Directed bench for acia_uart_rx: table of single-frame vectors plus break, overrun, glitch and reset sequences.
module tb_acia_uart_rx;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] baud_div_i;
    logic [1:0]  word_len_i;
    logic        parity_en_i;
    logic [1:0]  parity_mode_i;
    logic        rx_i;
    logic        rd_i;
    logic        clr_err_i;
    logic [7:0]  data_o;
    logic        valid_o, parity_err_o, framing_err_o, break_o, overrun_o;
    logic [4:0]  count_o;

    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    acia_uart_rx #(.FIFO_DEPTH(4), .OVERSAMPLE(16)) dut (
        .clk           (clk),
        .reset         (reset),
        .baud_div_i    (baud_div_i),
        .word_len_i    (word_len_i),
        .parity_en_i   (parity_en_i),
        .parity_mode_i (parity_mode_i),
        .rx_i          (rx_i),
        .rd_i          (rd_i),
        .clr_err_i     (clr_err_i),
        .data_o        (data_o),
        .valid_o       (valid_o),
        .parity_err_o  (parity_err_o),
        .framing_err_o (framing_err_o),
        .break_o       (break_o),
        .overrun_o     (overrun_o),
        .count_o       (count_o)
    );

    typedef struct {
        logic [15:0] div;
        logic [1:0]  wl;
        logic        pen;
        logic [1:0]  pmode;
        logic        pbit;
        logic        stopb;
        logic [7:0]  tx;
        logic [7:0]  exp_data;
        logic        exp_perr;
        logic        exp_ferr;
        logic        exp_brk;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic int bit_clks(input logic [15:0] div);
        return 16 * (int'(div) + 1);
    endfunction

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input logic [7:0] d, input int nbits, input logic pen,
                        input logic pbit, input logic stopb, input int bclk);
        rx_i = 1'b0;
        idle(bclk);
        for (int i = 0; i < nbits; i++) begin
            rx_i = d[i];
            idle(bclk);
        end
        if (pen) begin
            rx_i = pbit;
            idle(bclk);
        end
        rx_i = stopb;
        idle(bclk);
        rx_i = 1'b1;
    endtask

    task automatic send8n1(input logic [7:0] d, input int bclk);
        send(d, 8, 1'b0, 1'b0, 1'b1, bclk);
        idle(2 * bclk);
    endtask

    task automatic pop();
        @(negedge clk) rd_i = 1'b1;
        @(negedge clk) rd_i = 1'b0;
    endtask

    initial begin
        int bc;
        reset = 1'b1;
        baud_div_i = 16'd28;
        word_len_i = 2'b00;
        parity_en_i = 1'b0;
        parity_mode_i = 2'b00;
        rx_i = 1'b1;
        rd_i = 1'b0;
        clr_err_i = 1'b0;

        vecs[0] = '{16'd28, 2'b00, 1'b0, 2'b00, 1'b0, 1'b1, 8'hA5, 8'hA5, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{16'd3,  2'b01, 1'b1, 2'b01, 1'b1, 1'b1, 8'h41, 8'h41, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{16'd3,  2'b01, 1'b1, 2'b01, 1'b0, 1'b1, 8'h41, 8'h41, 1'b0, 1'b0, 1'b0};
        vecs[3] = '{16'd3,  2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 8'h3C, 8'h3C, 1'b0, 1'b1, 1'b0};
        vecs[4] = '{16'd3,  2'b00, 1'b1, 2'b00, 1'b0, 1'b1, 8'h07, 8'h07, 1'b0, 1'b0, 1'b0};
        vecs[5] = '{16'd3,  2'b10, 1'b1, 2'b10, 1'b1, 1'b1, 8'h2A, 8'h2A, 1'b0, 1'b0, 1'b0};
        vecs[6] = '{16'd3,  2'b11, 1'b1, 2'b11, 1'b1, 1'b1, 8'hFF, 8'h1F, 1'b1, 1'b0, 1'b0};
        vecs[7] = '{16'd3,  2'b01, 1'b0, 2'b00, 1'b0, 1'b1, 8'hC1, 8'h41, 1'b0, 1'b0, 1'b0};

        idle(5);
        chk("rst_valid", 32'(valid_o), 32'd0);
        chk("rst_data", 32'(data_o), 32'd0);
        chk("rst_count", 32'(count_o), 32'd0);
        chk("rst_errs", 32'({parity_err_o, framing_err_o, break_o, overrun_o}), 32'd0);
        reset = 1'b0;
        idle(5);

        for (int k = 0; k < 8; k++) begin
            bc = bit_clks(vecs[k].div);
            baud_div_i = vecs[k].div;
            word_len_i = vecs[k].wl;
            parity_en_i = vecs[k].pen;
            parity_mode_i = vecs[k].pmode;
            idle(2 * bc);
            send(vecs[k].tx, 8 - int'(vecs[k].wl), vecs[k].pen, vecs[k].pbit, vecs[k].stopb, bc);
            idle(2 * bc);
            chk($sformatf("v%0d_valid", k), 32'(valid_o), 32'd1);
            chk($sformatf("v%0d_count", k), 32'(count_o), 32'd1);
            chk($sformatf("v%0d_data", k), 32'(data_o), 32'(vecs[k].exp_data));
            chk($sformatf("v%0d_perr", k), 32'(parity_err_o), 32'(vecs[k].exp_perr));
            chk($sformatf("v%0d_ferr", k), 32'(framing_err_o), 32'(vecs[k].exp_ferr));
            chk($sformatf("v%0d_brk", k), 32'(break_o), 32'(vecs[k].exp_brk));
            pop();
            chk($sformatf("v%0d_popvalid", k), 32'(valid_o), 32'd0);
            chk($sformatf("v%0d_popcount", k), 32'(count_o), 32'd0);
        end

        baud_div_i = 16'd3;
        word_len_i = 2'b00;
        parity_en_i = 1'b0;
        bc = bit_clks(16'd3);
        idle(2 * bc);

        // Held break: one entry only, none while the line stays low.
        rx_i = 1'b0;
        idle(30 * bc);
        chk("brk_held_count", 32'(count_o), 32'd1);
        rx_i = 1'b1;
        idle(2 * bc);
        chk("brk_count", 32'(count_o), 32'd1);
        chk("brk_data", 32'(data_o), 32'd0);
        chk("brk_flag", 32'(break_o), 32'd1);
        chk("brk_ferr", 32'(framing_err_o), 32'd1);
        pop();

        // Overrun: five frames into a four-entry FIFO.
        for (int k = 1; k <= 5; k++) send8n1(8'(k), bc);
        chk("ovr_count", 32'(count_o), 32'd4);
        chk("ovr_flag", 32'(overrun_o), 32'd1);
        for (int k = 1; k <= 4; k++) begin
            chk($sformatf("ovr_data%0d", k), 32'(data_o), 32'(k));
            pop();
        end
        chk("ovr_empty", 32'(valid_o), 32'd0);
        chk("ovr_sticky", 32'(overrun_o), 32'd1);
        @(negedge clk) clr_err_i = 1'b1;
        @(negedge clk) clr_err_i = 1'b0;
        chk("ovr_clr", 32'(overrun_o), 32'd0);

        // Glitch of four ticks is rejected as a false start.
        rx_i = 1'b0;
        idle(4 * 4);
        rx_i = 1'b1;
        idle(2 * bc);
        chk("glitch_valid", 32'(valid_o), 32'd0);
        send8n1(8'h7E, bc);
        chk("glitch_next_valid", 32'(valid_o), 32'd1);
        chk("glitch_next_data", 32'(data_o), 32'h7E);
        chk("glitch_next_errs", 32'({parity_err_o, framing_err_o, break_o}), 32'd0);
        pop();

        // Reset during data bit 3 with two entries queued.
        send8n1(8'h11, bc);
        send8n1(8'h22, bc);
        chk("rstm_pre_count", 32'(count_o), 32'd2);
        rx_i = 1'b0;
        idle(bc);
        for (int i = 0; i < 3; i++) begin
            rx_i = (i % 2 == 0);
            idle(bc);
        end
        rx_i = 1'b0;
        idle(bc / 2);
        reset = 1'b1;
        idle(3);
        chk("rstm_valid", 32'(valid_o), 32'd0);
        chk("rstm_count", 32'(count_o), 32'd0);
        rx_i = 1'b1;
        reset = 1'b0;
        idle(12 * bc);
        chk("rstm_quiet", 32'(valid_o), 32'd0);
        send8n1(8'h55, bc);
        chk("rstm_next_count", 32'(count_o), 32'd1);
        chk("rstm_next_data", 32'(data_o), 32'h55);
        chk("rstm_next_errs", 32'({parity_err_o, framing_err_o, break_o, overrun_o}), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
